// File: rtl/mouse_position_tracker.sv
// mouse_position_tracker: turns raw PS/2 mouse packets into bounded absolute
// X/Y coordinates, a saturating wheel count and button edge events.
// Two-stage pipeline: stage 1 decodes and scales the deltas, stage 2
// accumulates them into the registered outputs. Accepts one packet per cycle.
module mouse_position_tracker #(
    parameter int W        = 8,
    parameter int LIMIT_X  = 160,
    parameter int LIMIT_Y  = 120,
    parameter int ZW       = 8,
    parameter int INVERT_Y = 0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 PKT_VALID,
    input  logic [7:0]           STATUS,
    input  logic [7:0]           DX,
    input  logic [7:0]           DY,
    input  logic [7:0]           DZ,
    input  logic [1:0]           DPI,
    input  logic                 WRAP,
    input  logic                 RECENTER,
    output logic [W-1:0]         POS_X,
    output logic [W-1:0]         POS_Y,
    output logic signed [ZW-1:0] WHEEL,
    output logic [2:0]           BUTTONS,
    output logic [2:0]           BTN_PRESS,
    output logic [2:0]           BTN_RELEASE,
    output logic                 UPDATED
);

    // Internal arithmetic width: wide enough for pos + a full-range delta
    // (+/-256) even when W is small.
    localparam int NW = (W + 2 > 11) ? W + 2 : 11;

    localparam logic signed [NW-1:0] LIM_X    = NW'(LIMIT_X);
    localparam logic signed [NW-1:0] LIM_Y    = NW'(LIMIT_Y);
    localparam logic [W-1:0]         CENTER_X = W'(LIMIT_X / 2);
    localparam logic [W-1:0]         CENTER_Y = W'(LIMIT_Y / 2);

    localparam logic signed [ZW:0] WHEEL_MAX = (ZW+1)'((2 ** (ZW - 1)) - 1);
    localparam logic signed [ZW:0] WHEEL_MIN = (ZW+1)'(-(2 ** (ZW - 1)));

    // Decode a 9-bit signed delta (with overflow forcing) and scale it by a
    // right shift that truncates toward zero for both signs.
    function automatic logic signed [NW-1:0] scaleDelta(
        input logic       sign,
        input logic       ovf,
        input logic [7:0] mag,
        input logic [1:0] dpi
    );
        logic signed [8:0]    raw;
        logic signed [NW-1:0] d;
        logic [NW-1:0]        absVal;
        raw = {sign, mag};
        if (ovf)
            d = sign ? NW'(-256) : NW'(255);
        else
            d = NW'(raw);
        absVal = (d < 0) ? -d : d;
        absVal = absVal >> dpi;
        return (d < 0) ? -signed'(absVal) : signed'(absVal);
    endfunction

    // Symmetric saturation of a step to +/-(lim-1); keeps wrap arithmetic to
    // a single add/subtract of the limit.
    function automatic logic signed [NW-1:0] limitStep(
        input logic signed [NW-1:0] s,
        input logic signed [NW-1:0] lim
    );
        logic signed [NW-1:0] top;
        top = lim - NW'(1);
        if (s > top)
            return top;
        else if (s < -top)
            return -top;
        else
            return s;
    endfunction

    // New coordinate from current position and step, clamped or wrapped.
    function automatic logic [W-1:0] nextPos(
        input logic [W-1:0]         pos,
        input logic signed [NW-1:0] s,
        input logic signed [NW-1:0] lim,
        input logic                 wrap
    );
        logic signed [NW-1:0] n;
        n = signed'(NW'(pos)) + s;
        if (wrap) begin
            if (n < 0)
                n = n + lim;
            else if (n >= lim)
                n = n - lim;
        end else begin
            if (n < 0)
                n = '0;
            else if (n > lim - NW'(1))
                n = lim - NW'(1);
        end
        return W'(n);
    endfunction

    // Saturating signed wheel accumulation.
    function automatic logic signed [ZW-1:0] satWheel(
        input logic signed [ZW-1:0] w,
        input logic signed [ZW-1:0] z
    );
        logic signed [ZW:0] sum;
        sum = (ZW+1)'(w) + (ZW+1)'(z);
        if (sum > WHEEL_MAX)
            return ZW'(WHEEL_MAX);
        else if (sum < WHEEL_MIN)
            return ZW'(WHEEL_MIN);
        else
            return ZW'(sum);
    endfunction

    // Status bit 3 and the upper wheel nibble carry no information here.
    logic unusedBits;
    assign unusedBits = ^{STATUS[3], DZ[7:4]};

    logic signed [NW-1:0] scaledX, scaledY, stepX, stepY;
    logic signed [3:0]    dzNibble;
    logic signed [ZW-1:0] wheelStep;

    logic signed [NW-1:0] stepX_p1, stepY_p1;
    logic signed [ZW-1:0] wheelStep_p1;
    logic [2:0]           buttons_p1;
    logic                 wrap_p1;
    logic                 vld_p1;

    // Decode, scale, optionally invert Y and pre-saturate the raw packet.
    always_comb begin
        scaledX = scaleDelta(STATUS[4], STATUS[6], DX, DPI);
        scaledY = scaleDelta(STATUS[5], STATUS[7], DY, DPI);
        if (INVERT_Y != 0)
            scaledY = -scaledY;
        stepX     = WRAP ? limitStep(scaledX, LIM_X) : scaledX;
        stepY     = WRAP ? limitStep(scaledY, LIM_Y) : scaledY;
        dzNibble  = DZ[3:0];
        wheelStep = ZW'(dzNibble);
    end

    // ---- stage 1: decoded packet registers ----

    // Stage-1 valid; reset drops any in-flight packet and ignores strobes.
    always_ff @(posedge CLK) begin
        if (!RESET)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= PKT_VALID;
    end

    // Stage-1 data capture, only meaningful while vld_p1 is set.
    always_ff @(posedge CLK) begin
        if (PKT_VALID) begin
            stepX_p1     <= stepX;
            stepY_p1     <= stepY;
            wheelStep_p1 <= wheelStep;
            buttons_p1   <= STATUS[2:0];
            wrap_p1      <= WRAP;
        end
    end

    // ---- stage 2: accumulated outputs ----

    // Apply a stage-1 packet to position, wheel and buttons; recenter wins
    // over the position/wheel update but buttons and pulses still land.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            POS_X       <= CENTER_X;
            POS_Y       <= CENTER_Y;
            WHEEL       <= '0;
            BUTTONS     <= '0;
            BTN_PRESS   <= '0;
            BTN_RELEASE <= '0;
            UPDATED     <= 1'b0;
        end else begin
            UPDATED <= vld_p1;
            if (vld_p1) begin
                BUTTONS     <= buttons_p1;
                BTN_PRESS   <= buttons_p1 & ~BUTTONS;
                BTN_RELEASE <= ~buttons_p1 & BUTTONS;
            end else begin
                BTN_PRESS   <= '0;
                BTN_RELEASE <= '0;
            end
            if (RECENTER) begin
                POS_X <= CENTER_X;
                POS_Y <= CENTER_Y;
                WHEEL <= '0;
            end else if (vld_p1) begin
                POS_X <= nextPos(POS_X, stepX_p1, LIM_X, wrap_p1);
                POS_Y <= nextPos(POS_Y, stepY_p1, LIM_Y, wrap_p1);
                WHEEL <= satWheel(WHEEL, wheelStep_p1);
            end
        end
    end

endmodule

// File: tb/tb_mouse_position_tracker.sv
// Directed bench for mouse_position_tracker: one default instance and one
// with INVERT_Y=1, ZW=4 sharing the same stimulus.
module tb_mouse_position_tracker;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       PKT_VALID = 1'b0;
    logic [7:0] STATUS = 8'h08;
    logic [7:0] DX = 8'h00;
    logic [7:0] DY = 8'h00;
    logic [7:0] DZ = 8'h00;
    logic [1:0] DPI = 2'd0;
    logic       WRAP = 1'b0;
    logic       RECENTER = 1'b0;

    logic [7:0]        posX1, posY1, posX2, posY2;
    logic signed [7:0] wheel1;
    logic signed [3:0] wheel2;
    logic [2:0]        buttons1, press1, release1, buttons2, press2, release2;
    logic              updated1, updated2;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mouse_position_tracker #(.W(8), .LIMIT_X(160), .LIMIT_Y(120), .ZW(8), .INVERT_Y(0)) dut1 (
        .CLK(CLK), .RESET(RESET), .PKT_VALID(PKT_VALID), .STATUS(STATUS),
        .DX(DX), .DY(DY), .DZ(DZ), .DPI(DPI), .WRAP(WRAP), .RECENTER(RECENTER),
        .POS_X(posX1), .POS_Y(posY1), .WHEEL(wheel1), .BUTTONS(buttons1),
        .BTN_PRESS(press1), .BTN_RELEASE(release1), .UPDATED(updated1)
    );

    mouse_position_tracker #(.W(8), .LIMIT_X(160), .LIMIT_Y(120), .ZW(4), .INVERT_Y(1)) dut2 (
        .CLK(CLK), .RESET(RESET), .PKT_VALID(PKT_VALID), .STATUS(STATUS),
        .DX(DX), .DY(DY), .DZ(DZ), .DPI(DPI), .WRAP(WRAP), .RECENTER(RECENTER),
        .POS_X(posX2), .POS_Y(posY2), .WHEEL(wheel2), .BUTTONS(buttons2),
        .BTN_PRESS(press2), .BTN_RELEASE(release2), .UPDATED(updated2)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        PKT_VALID = 1'b0;
        RECENTER  = 1'b0;
        STATUS = 8'h08; DX = 8'h00; DY = 8'h00; DZ = 8'h00; DPI = 2'd0; WRAP = 1'b0;
        RESET = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
    endtask

    // Drives one strobe; returns #1 after the edge that sampled it.
    task automatic sendPkt(input logic [7:0] st, input logic [7:0] dx,
                           input logic [7:0] dy, input logic [7:0] dz);
        STATUS = st; DX = dx; DY = dy; DZ = dz;
        PKT_VALID = 1'b1;
        tick();
        PKT_VALID = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        checks++; if (posX1 !== 8'd80) begin errors++; $display("FAIL reset_posx: got %0d want 80", posX1); end
        checks++; if (posY1 !== 8'd60) begin errors++; $display("FAIL reset_posy: got %0d want 60", posY1); end
        checks++; if (wheel1 !== 8'sd0) begin errors++; $display("FAIL reset_wheel: got %0d want 0", wheel1); end
        checks++; if ({updated1, press1, release1, buttons1} !== 10'd0) begin errors++; $display("FAIL reset_pulses: got %b want 0", {updated1, press1, release1, buttons1}); end
        // reset one cycle after the strobe discards the packet
        sendPkt(8'h08, 8'h0A, 8'h00, 8'h00);
        RESET = 1'b0;
        tick();
        checks++; if (updated1 !== 1'b0) begin errors++; $display("FAIL reset_inflight_upd: got %b want 0", updated1); end
        RESET = 1'b1;
        tick();
        tick();
        checks++; if (updated1 !== 1'b0) begin errors++; $display("FAIL reset_inflight_upd2: got %b want 0", updated1); end
        checks++; if (posX1 !== 8'd80) begin errors++; $display("FAIL reset_inflight_posx: got %0d want 80", posX1); end
    endtask

    task automatic test_basic_move();
        doReset();
        DPI = 2'd0;
        sendPkt(8'h08, 8'h0A, 8'h00, 8'h00);
        checks++; if (updated1 !== 1'b0) begin errors++; $display("FAIL basic_early_upd: got %b want 0", updated1); end
        tick();
        checks++; if (updated1 !== 1'b1) begin errors++; $display("FAIL basic_upd: got %b want 1", updated1); end
        checks++; if (posX1 !== 8'd90) begin errors++; $display("FAIL basic_posx90: got %0d want 90", posX1); end
        checks++; if (posY1 !== 8'd60) begin errors++; $display("FAIL basic_posy: got %0d want 60", posY1); end
        tick();
        checks++; if (updated1 !== 1'b0) begin errors++; $display("FAIL basic_upd_end: got %b want 0", updated1); end
        DPI = 2'd2;
        sendPkt(8'h18, 8'hF6, 8'h00, 8'h00);
        tick();
        checks++; if (posX1 !== 8'd88) begin errors++; $display("FAIL basic_posx88: got %0d want 88", posX1); end
        DPI = 2'd1;
        sendPkt(8'h18, 8'hFF, 8'h00, 8'h00);
        tick();
        checks++; if (posX1 !== 8'd88) begin errors++; $display("FAIL basic_trunc: got %0d want 88", posX1); end
        checks++; if (updated1 !== 1'b1) begin errors++; $display("FAIL basic_trunc_upd: got %b want 1", updated1); end
    endtask

    task automatic test_overflow();
        doReset();
        sendPkt(8'h48, 8'h00, 8'h00, 8'h00);
        tick();
        checks++; if (posX1 !== 8'd159) begin errors++; $display("FAIL ovf_clamp_hi: got %0d want 159", posX1); end
        doReset();
        WRAP = 1'b1;
        sendPkt(8'h48, 8'h00, 8'h00, 8'h00);
        WRAP = 1'b0;
        tick();
        checks++; if (posX1 !== 8'd79) begin errors++; $display("FAIL ovf_wrap: got %0d want 79", posX1); end
        doReset();
        sendPkt(8'h58, 8'h00, 8'h00, 8'h00);
        tick();
        checks++; if (posX1 !== 8'd0) begin errors++; $display("FAIL ovf_clamp_lo: got %0d want 0", posX1); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        doReset();
        STATUS = 8'h08; DX = 8'h00; DY = 8'h05; DZ = 8'h00;
        PKT_VALID = 1'b1;
        tick();
        if (updated2) pulses++;
        tick();
        if (updated2) pulses++;
        checks++; if (posY2 !== 8'd55) begin errors++; $display("FAIL b2b_y55: got %0d want 55", posY2); end
        tick();
        if (updated2) pulses++;
        PKT_VALID = 1'b0;
        checks++; if (posY2 !== 8'd50) begin errors++; $display("FAIL b2b_y50: got %0d want 50", posY2); end
        tick();
        if (updated2) pulses++;
        checks++; if (posY2 !== 8'd45) begin errors++; $display("FAIL b2b_y45: got %0d want 45", posY2); end
        checks++; if (posY1 !== 8'd75) begin errors++; $display("FAIL b2b_noinv_y75: got %0d want 75", posY1); end
        tick();
        if (updated2) pulses++;
        checks++; if (pulses != 3) begin errors++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
    endtask

    task automatic test_wheel();
        doReset();
        STATUS = 8'h08; DX = 8'h00; DY = 8'h00; DZ = 8'h0F;
        PKT_VALID = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        PKT_VALID = 1'b0;
        tick();
        checks++; if (wheel1 !== -8'sd3) begin errors++; $display("FAIL wheel_neg3: got %0d want -3", wheel1); end
        checks++; if (wheel2 !== -4'sd3) begin errors++; $display("FAIL wheel_neg3_zw4: got %0d want -3", wheel2); end
        doReset();
        DZ = 8'h07;
        PKT_VALID = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        PKT_VALID = 1'b0;
        tick();
        checks++; if (wheel2 !== 4'sd7) begin errors++; $display("FAIL wheel_sat: got %0d want 7", wheel2); end
        checks++; if (wheel1 !== 8'sd70) begin errors++; $display("FAIL wheel_70: got %0d want 70", wheel1); end
        // recenter on the stage-2 edge of packet A while packet B sits in stage 1
        STATUS = 8'h08; DX = 8'h05; DY = 8'h00; DZ = 8'h01;
        PKT_VALID = 1'b1;
        tick();
        RECENTER = 1'b1;
        tick();
        RECENTER = 1'b0;
        PKT_VALID = 1'b0;
        checks++; if (posX1 !== 8'd80) begin errors++; $display("FAIL recenter_posx: got %0d want 80", posX1); end
        checks++; if (wheel1 !== 8'sd0) begin errors++; $display("FAIL recenter_wheel: got %0d want 0", wheel1); end
        checks++; if (updated1 !== 1'b1) begin errors++; $display("FAIL recenter_upd: got %b want 1", updated1); end
        tick();
        checks++; if (posX1 !== 8'd85) begin errors++; $display("FAIL recenter_next_posx: got %0d want 85", posX1); end
        checks++; if (wheel1 !== 8'sd1) begin errors++; $display("FAIL recenter_next_wheel: got %0d want 1", wheel1); end
    endtask

    task automatic test_buttons();
        doReset();
        sendPkt(8'h09, 8'h00, 8'h00, 8'h00);
        tick();
        checks++; if (press1 !== 3'b001) begin errors++; $display("FAIL btn_press1: got %b want 001", press1); end
        checks++; if (release1 !== 3'b000) begin errors++; $display("FAIL btn_release1: got %b want 000", release1); end
        tick();
        checks++; if (press1 !== 3'b000) begin errors++; $display("FAIL btn_press1_end: got %b want 000", press1); end
        sendPkt(8'h0C, 8'h00, 8'h00, 8'h00);
        tick();
        checks++; if (press1 !== 3'b100) begin errors++; $display("FAIL btn_press2: got %b want 100", press1); end
        checks++; if (release1 !== 3'b001) begin errors++; $display("FAIL btn_release2: got %b want 001", release1); end
        tick();
        checks++; if ({press1, release1} !== 6'd0) begin errors++; $display("FAIL btn_pulse_end: got %b want 000000", {press1, release1}); end
        checks++; if (buttons1 !== 3'b100) begin errors++; $display("FAIL btn_state: got %b want 100", buttons1); end
    endtask

    initial begin
        test_reset();
        test_basic_move();
        test_overflow();
        test_back_to_back();
        test_wheel();
        test_buttons();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mouse_position_tracker.md
# mouse_position_tracker

Parametrised position/wheel/button tracker that sits between the PS/2 mouse master state machine (raw status, DX, DY, DZ bytes plus a one-cycle packet strobe) and display/consumer logic. It converts each raw packet into bounded absolute X/Y coordinates, a saturating wheel count and button edge events. It generalises position tracking with configurable coordinate width and limits, clamp or wrap mode, optional Y inversion, and a two-stage pipeline that accepts a packet every cycle.

## Interface
- W, 8: coordinate width in bits.
- LIMIT_X, 160: X range is 0..LIMIT_X-1; must satisfy 2 ≤ LIMIT_X ≤ 2^W-1.
- LIMIT_Y, 120: Y range is 0..LIMIT_Y-1; same constraint.
- ZW, 8: wheel accumulator width, signed.
- INVERT_Y, 0: 1 negates the scaled DY before accumulation, so PS/2 "up" moves toward row 0.
- CLK  in  1  system clock; all state is updated on the rising edge.
- RESET  in  1  synchronous, active-low reset; RESET=0 at a rising edge resets the block.
- PKT_VALID  in  1  one-cycle strobe; STATUS, DX, DY and DZ are valid in the same cycle.
- STATUS  in  8  PS/2 byte 0: [7] Y overflow, [6] X overflow, [5] Y sign, [4] X sign, [2:0] buttons M/R/L.
- DX, DY  in  8 each  raw movement magnitude bytes.
- DZ  in  8  wheel byte; only [3:0] is used, as a signed value.
- DPI  in  2  right-shift amount for X/Y scaling; sampled together with PKT_VALID.
- WRAP  in  1  0 = clamp at the edges, 1 = wrap around; sampled together with PKT_VALID.
- RECENTER  in  1  synchronous request that returns the position to centre and clears the wheel count.
- POS_X, POS_Y  out  W  current position.
- WHEEL  out  ZW  signed, saturating wheel accumulator.
- BUTTONS  out  3  STATUS[2:0] from the last completed packet.
- BTN_PRESS, BTN_RELEASE  out  3 each  one-cycle pulses on a 0→1 or 1→0 change of each button.
- UPDATED  out  1  one-cycle pulse when the outputs reflect a new packet.

## Operation
- Stage 1 is registered on the edge where PKT_VALID=1 is sampled.
  - d = {sign, byte} as a 9-bit signed value.
  - If the overflow bit is set, d becomes -256 when sign=1, otherwise +255.
  - Scaling truncates toward zero: s = d≥0 ? d>>DPI : -((-d)>>DPI). For example, -1 with DPI=1 gives 0, and -10 with DPI=2 gives -2.
  - When INVERT_Y=1, sy = -sy (10-bit signed).
  - In wrap mode, s is pre-saturated to ±(LIMIT-1) on each axis.
  - DZ[3:0] is sign-extended to ZW bits.
  - Stage 1 also registers the button bits, the WRAP value and a valid bit.
- Stage 2 is registered on the next edge when stage 1 is valid.
  - n = pos + s, computed in W+2 bits signed.
  - Clamp mode: n<0 gives 0; n>LIMIT-1 gives LIMIT-1; otherwise n.
  - Wrap mode: n<0 gives n+LIMIT; n≥LIMIT gives n-LIMIT; otherwise n.
  - WHEEL = sat(WHEEL + z), bounded to [-2^(ZW-1), 2^(ZW-1)-1].
  - BUTTONS takes the new bits. BTN_PRESS = new & ~old; BTN_RELEASE = ~new & old.
  - UPDATED = 1 for this cycle.
- Back-to-back packets on consecutive cycles are each applied in order, and no packet is dropped. Stage 2 always adds to the current registered position.
- RECENTER=1 at an edge sets POS_X = LIMIT_X/2 and POS_Y = LIMIT_Y/2 (floor), and WHEEL = 0.
  - If stage 2 is valid on the same edge, RECENTER wins: the position and wheel delta are discarded.
  - BUTTONS, the edge pulses and UPDATED still take effect in that case.
  - A packet in stage 1 at that edge is applied normally on the following edge.
- Reset values:
  - POS_X = LIMIT_X/2, POS_Y = LIMIT_Y/2.
  - WHEEL, BUTTONS, BTN_PRESS, BTN_RELEASE and UPDATED are all 0.
  - The stage 1 valid bit is 0. Reset discards any in-flight packet.
- PKT_VALID asserted during reset is ignored.

## Timing
- Latency: PKT_VALID sampled at edge k gives new outputs and UPDATED=1 in the cycle after edge k+1, i.e. 2 cycles.
- Throughput: 1 packet per cycle. No backpressure; the upstream block has no ready signal.
- Every output is registered, with no combinational path from any input.
- The pulses (UPDATED, BTN_PRESS, BTN_RELEASE) last exactly 1 cycle and return to 0 unless another packet completes on the next edge.
- DPI and WRAP changes take effect only on packets sampled after the change.

## Test plan
1. **Reset:** defaults, RESET=0 for 2 cycles then 1 → POS_X=80, POS_Y=60, WHEEL=0, no pulses. Repeat with RESET=0 asserted 1 cycle after PKT_VALID → no UPDATED and the position is unchanged.
2. **Basic move:** STATUS=0x08, DX=0x0A, DY=0x00, DPI=0 → POS_X=90 with UPDATED high exactly 2 cycles after the strobe. Then STATUS=0x18, DX=0xF6, DPI=2 → POS_X=88. Then STATUS=0x18, DX=0xFF, DPI=1 → POS_X stays 88.
3. **X overflow:** STATUS=0x48 from POS_X=80.
   - WRAP=0 → POS_X=159.
   - WRAP=1 → delta is saturated to 159 → POS_X=79.
   - STATUS=0x58 with WRAP=0 → POS_X=0.
4. **Y inversion and back-to-back:** INVERT_Y=1, STATUS=0x08, DY=0x05 on 3 consecutive cycles from POS_Y=60 → POS_Y=55, 50, 45 on consecutive cycles, with 3 UPDATED pulses.
5. **Wheel:** DZ=0x0F three times → WHEEL=-3. With ZW=4, DZ=0x07 ten times → WHEEL saturates at 7. RECENTER asserted on the same edge as a stage 2 update with DX=0x05 → POS_X=80, WHEEL=0, UPDATED=1.
6. **Buttons:** STATUS=0x09 then 0x0C → first BTN_PRESS=001, then BTN_PRESS=100 and BTN_RELEASE=001, each pulse lasting 1 cycle, with BUTTONS=100 at the end.
